// File: rtl/u8acc_pkg.sv
// Shared types, parameter-port addresses and sequencer states for the u8 accelerator blocks.
package u8acc_pkg;

  typedef logic [7:0]  u8_t;
  typedef logic [10:0] u11_t;
  typedef logic [19:0] u20_t;
  typedef logic [23:0] u24_t;
  typedef logic [31:0] u32_t;

  localparam u8_t PADR_OUTW  = 8'd7;
  localparam u8_t PADR_PH    = 8'd9;
  localparam u8_t PADR_NCHEN = 8'd22;
  localparam u8_t PADR_LANE0 = 8'd24;
  localparam u8_t DESC_LAST  = 8'd22;

  // Last count value before a wait times out: 1024 and 2^24-1 cycles.
  localparam u24_t WDOG_RUN_LAST  = 24'd1023;
  localparam u24_t WDOG_IDLE_LAST = 24'hFFFFFE;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_WRITE, ST_SPLIT_WR, ST_SPLIT_STEP,
    ST_KICK, ST_WAIT_RUN, ST_WAIT_IDLE, ST_NEXT
  } seq_state_t;

  function automatic u24_t desc_adr(input u24_t base, input u8_t layer, input u8_t w,
                                    input int desc_words);
    return base + (u24_t'(layer) * u24_t'(desc_words * 4)) + u24_t'({w, 2'b00});
  endfunction

endpackage

// File: rtl/u8lane_split.sv
// Lane start-position generator: lane i starts at linear offset i*pH, split into (y, x)
// by repeated subtraction of outW.
module u8lane_split
  import u8acc_pkg::*;
#(
  parameter int Np = 1
) (
  input  logic aclk,
  input  logic arst_n,
  input  logic i_go,
  input  u11_t i_outw,
  input  u20_t i_ph,
  output u8_t  o_lane,
  output u11_t o_x,
  output u11_t o_y,
  output logic o_wr,
  output logic o_fin
);

  localparam logic [20:0] STEP_SAT = 21'h100000;

  seq_state_t  r_state;
  u8_t         r_lane;
  u11_t        r_x;
  u11_t        r_y;
  logic [20:0] r_acc;
  logic [20:0] r_cnt;
  logic        r_fin;

  // Lane walk: emit one position, then divide the next offset down to a column.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;
      r_lane  <= 8'd0;
      r_x     <= 11'd0;
      r_y     <= 11'd0;
      r_acc   <= 21'd0;
      r_cnt   <= 21'd0;
      r_fin   <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_go) begin
            r_lane  <= 8'd0;
            r_x     <= 11'd0;
            r_y     <= 11'd0;
            r_state <= ST_SPLIT_WR;
          end
        end
        ST_SPLIT_WR: begin
          if (r_lane == u8_t'(Np - 1)) begin
            r_fin   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_acc   <= {10'd0, r_x} + {1'b0, i_ph};
            r_cnt   <= 21'd0;
            r_state <= ST_SPLIT_STEP;
          end
        end
        ST_SPLIT_STEP: begin
          // A zero outW never lets acc drop below it; the counter bounds the loop.
          if (r_cnt == STEP_SAT) begin
            r_x     <= 11'd0;
            r_lane  <= r_lane + 8'd1;
            r_state <= ST_SPLIT_WR;
          end else if (r_acc >= {10'd0, i_outw}) begin
            r_acc <= r_acc - {10'd0, i_outw};
            r_y   <= r_y + 11'd1;
            r_cnt <= r_cnt + 21'd1;
          end else begin
            r_x     <= r_acc[10:0];
            r_lane  <= r_lane + 8'd1;
            r_state <= ST_SPLIT_WR;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_lane = r_lane;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_wr   = (r_state == ST_SPLIT_WR);
  assign o_fin  = r_fin;

endmodule

// File: rtl/u8layer_seq.sv
// Descriptor-driven layer sequencer for u8adrgen: fetch, write params, place lanes, kick, wait.
// Optional watchdog on the run handshake enabled by defining SEQ_WDOG_EN.
module u8layer_seq
  import u8acc_pkg::*;
#(
  parameter int Np         = 1,
  parameter int DESC_WORDS = 32
) (
  input  logic        aclk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [23:0] desc_base,
  input  logic [7:0]  n_layers,
  output logic        busy,
  output logic        done,
  output logic [7:0]  layer_idx,
  output logic        mrd_req,
  output logic [23:0] mrd_adr,
  input  logic        mrd_ack,
  input  logic [31:0] mrd_data,
  output logic        pwe,
  output logic [7:0]  padr,
  output logic [31:0] pdata,
  output logic        kick,
  input  logic        run,
  output logic        err
);

  seq_state_t r_state;
  u24_t       r_base;
  u8_t        r_nlay;
  u8_t        r_layer_idx;
  u8_t        r_w;
  u11_t       r_outw;
  u20_t       r_ph;
  logic       r_busy, r_done, r_mrd_req, r_pwe, r_kick, r_split_go;
  u24_t       r_mrd_adr;
  u8_t        r_padr;
  u32_t       r_pdata;
`ifdef SEQ_WDOG_EN
  u24_t       r_wdog;
  logic       r_err;
`endif

  u8_t  w_lane;
  u11_t w_x, w_y;
  logic w_split_wr, w_split_fin;

  u8lane_split #(.Np(Np)) u_split (
    .aclk   (aclk),
    .arst_n (arst_n),
    .i_go   (r_split_go),
    .i_outw (r_outw),
    .i_ph   (r_ph),
    .o_lane (w_lane),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_wr   (w_split_wr),
    .o_fin  (w_split_fin)
  );

  // Sequencer FSM; every port output is a register set on the transition into its state.
  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      r_state <= ST_IDLE;     r_base <= 24'd0;     r_nlay <= 8'd0;
      r_layer_idx <= 8'd0;    r_w <= 8'd0;         r_outw <= 11'd0;
      r_ph <= 20'd0;          r_busy <= 1'b0;      r_done <= 1'b0;
      r_mrd_req <= 1'b0;      r_mrd_adr <= 24'd0;  r_pwe <= 1'b0;
      r_padr <= 8'd0;         r_pdata <= 32'd0;    r_kick <= 1'b0;
      r_split_go <= 1'b0;
`ifdef SEQ_WDOG_EN
      r_wdog <= 24'd0;        r_err <= 1'b0;
`endif
    end else begin
      r_done     <= 1'b0;
      r_split_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
`ifdef SEQ_WDOG_EN
            r_err <= 1'b0;
`endif
            r_base      <= desc_base;
            r_nlay      <= n_layers;
            r_layer_idx <= 8'd0;
            r_w         <= 8'd0;
            if (n_layers == 8'd0) begin
              r_done <= 1'b1;
            end else begin
              r_busy    <= 1'b1;
              r_mrd_req <= 1'b1;
              r_mrd_adr <= desc_adr(desc_base, 8'd0, 8'd0, DESC_WORDS);
              r_state   <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (mrd_ack) begin
            r_mrd_req <= 1'b0;
            r_pwe     <= 1'b1;
            r_padr    <= r_w;
            r_pdata   <= mrd_data;
            if (r_w == PADR_OUTW) r_outw <= mrd_data[10:0];
            if (r_w == PADR_PH)   r_ph   <= mrd_data[19:0];
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_pwe <= 1'b0;
          if (r_w == DESC_LAST) begin
            r_split_go <= 1'b1;
            r_state    <= ST_SPLIT_WR;
          end else begin
            r_w       <= r_w + 8'd1;
            r_mrd_req <= 1'b1;
            r_mrd_adr <= desc_adr(r_base, r_layer_idx, r_w + 8'd1, DESC_WORDS);
            r_state   <= ST_FETCH;
          end
        end
        ST_SPLIT_WR: begin
          r_pwe   <= w_split_wr;
          r_padr  <= PADR_LANE0 + w_lane;
          r_pdata <= {5'd0, w_y, 5'd0, w_x};
          if (w_split_fin) begin
            r_kick  <= 1'b1;
            r_state <= ST_KICK;
          end
        end
        ST_KICK: begin
          r_kick  <= 1'b0;
`ifdef SEQ_WDOG_EN
          r_wdog  <= 24'd0;
`endif
          r_state <= ST_WAIT_RUN;
        end
        ST_WAIT_RUN: begin
`ifdef SEQ_WDOG_EN
          if (run) begin
            r_wdog  <= 24'd0;
            r_state <= ST_WAIT_IDLE;
          end else if (r_wdog == WDOG_RUN_LAST) begin
            r_err <= 1'b1; r_done <= 1'b1; r_busy <= 1'b0; r_state <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 24'd1;
          end
`else
          if (run) r_state <= ST_WAIT_IDLE;
`endif
        end
        ST_WAIT_IDLE: begin
`ifdef SEQ_WDOG_EN
          if (!run) begin
            r_state <= ST_NEXT;
          end else if (r_wdog == WDOG_IDLE_LAST) begin
            r_err <= 1'b1; r_done <= 1'b1; r_busy <= 1'b0; r_state <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 24'd1;
          end
`else
          if (!run) r_state <= ST_NEXT;
`endif
        end
        ST_NEXT: begin
          r_layer_idx <= r_layer_idx + 8'd1;
          if (r_layer_idx + 8'd1 == r_nlay) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_w       <= 8'd0;
            r_mrd_req <= 1'b1;
            r_mrd_adr <= desc_adr(r_base, r_layer_idx + 8'd1, 8'd0, DESC_WORDS);
            r_state   <= ST_FETCH;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign layer_idx = r_layer_idx;
  assign mrd_req   = r_mrd_req;
  assign mrd_adr   = r_mrd_adr;
  assign pwe       = r_pwe;
  assign padr      = r_padr;
  assign pdata     = r_pdata;
  assign kick      = r_kick;
`ifdef SEQ_WDOG_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_u8layer_seq.sv
// Scoreboard bench for u8layer_seq with Np=4: expected fetch addresses and param writes are
// queued at start and consumed as the DUT issues them.
module tb_u8layer_seq;

  localparam int NP   = 4;
  localparam int OUTW = 8;
  localparam int PH   = 20;

  logic        aclk = 1'b0;
  logic        arst_n, start;
  logic [23:0] desc_base;
  logic [7:0]  n_layers;
  logic        busy, done;
  logic [7:0]  layer_idx;
  logic        mrd_req;
  logic [23:0] mrd_adr;
  logic        mrd_ack;
  logic [31:0] mrd_data;
  logic        pwe;
  logic [7:0]  padr;
  logic [31:0] pdata;
  logic        kick;
  logic        run;
  logic        err;

  always #5 aclk = ~aclk;

  u8layer_seq #(.Np(NP), .DESC_WORDS(32)) dut (
    .aclk(aclk), .arst_n(arst_n), .start(start), .desc_base(desc_base),
    .n_layers(n_layers), .busy(busy), .done(done), .layer_idx(layer_idx),
    .mrd_req(mrd_req), .mrd_adr(mrd_adr), .mrd_ack(mrd_ack), .mrd_data(mrd_data),
    .pwe(pwe), .padr(padr), .pdata(pdata), .kick(kick), .run(run), .err(err)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [39:0] exp_pw[$];
  logic [23:0] exp_adr[$];
  logic [23:0] tb_base = 24'd0;
  int          ack_mode = 0;
  bit          run_en = 1'b1;
  int          kick_cnt = 0;
  int          kick_base = 0;
  int          req_seen = 0;
  int          fall_cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [23:0] a, input logic [23:0] b);
    logic [23:0] off;
    off = a - b;
    if (off[6:2] == 5'd7) return 32'hABC0_0008;
    if (off[6:2] == 5'd9) return 32'h0F00_0014;
    return {8'hD0 ^ off[14:7], a};
  endfunction

  // Expected traffic for one layer; lane i starts at linear offset i*PH in a row of OUTW.
  task automatic push_layer(input logic [23:0] b, input int layer);
    logic [23:0] a;
    int pos;
    for (int w = 0; w < 23; w++) begin
      a = b + 24'(layer * 128) + 24'(w * 4);
      exp_adr.push_back(a);
      exp_pw.push_back({8'(w), mem_word(a, b)});
    end
    for (int i = 0; i < NP; i++) begin
      pos = i * PH;
      exp_pw.push_back({8'(24 + i), 5'd0, 11'(pos / OUTW), 5'd0, 11'(pos % OUTW)});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_ctrl"}, {busy, done, mrd_req, pwe, kick, err}, 6'd0);
    chk_eq({tag, "_data"}, {padr, pdata, mrd_adr}, 64'd0);
    chk_eq({tag, "_layer"}, layer_idx, 8'd0);
  endtask

  task automatic pulse_start(input logic [23:0] b, input int n);
    tb_base   = b;
    desc_base = b;
    n_layers  = 8'(n);
    kick_base = kick_cnt;
    start     = 1'b1;
    @(negedge aclk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (done) begin
        lat = i + 1;
        break;
      end
    end
    chk_eq("done_seen", lat > 0, 1'b1);
  endtask

  task automatic run_seq(input logic [23:0] b, input int n, input int mode);
    int lat;
    ack_mode = mode;
    for (int l = 0; l < n; l++) push_layer(b, l);
    pulse_start(b, n);
    chk_eq("busy_after_start", busy, 1'b1);
    chk_eq("first_adr", mrd_adr, b);
    if (n > 1) begin
      repeat (30) @(negedge aclk);
      desc_base = 24'hFF_FF00;
      start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      desc_base = b;
    end
    wait_done(6000, lat);
    chk_eq("done_after_fall", cyc - fall_cyc, 2);
    chk_eq("busy_at_done", busy, 1'b0);
    chk_eq("layer_idx_end", layer_idx, 8'(n));
    chk_eq("kick_count", kick_cnt - kick_base, n);
    chk_eq("pwe_q_empty", exp_pw.size(), 0);
    chk_eq("adr_q_empty", exp_adr.size(), 0);
    @(negedge aclk);
    chk_eq("done_one_cycle", done, 1'b0);
  endtask

  // Descriptor memory: ack after 0, 1 or 5 cycles; request must stay put meanwhile.
  initial begin
    logic [23:0] hold;
    int d;
    mrd_ack  = 1'b0;
    mrd_data = 32'd0;
    forever begin
      @(negedge aclk);
      mrd_ack = 1'b0;
      if (mrd_req && arst_n) begin
        hold = mrd_adr;
        d = 0;
        if (ack_mode != 0) begin
          case ($urandom_range(0, 2))
            0: d = 0;
            1: d = 1;
            default: d = 5;
          endcase
        end
        for (int k = 0; k < d; k++) begin
          @(negedge aclk);
          chk_eq("req_held", mrd_req, 1'b1);
          chk_eq("adr_stable", mrd_adr, hold);
        end
        mrd_data = mem_word(mrd_adr, tb_base);
        mrd_ack  = 1'b1;
      end
    end
  end

  // adrgen stand-in: run rises two cycles after kick and stays high for ten.
  initial begin
    run = 1'b0;
    forever begin
      @(negedge aclk);
      if (kick && run_en) begin
        repeat (2) @(negedge aclk);
        run = 1'b1;
        repeat (10) @(negedge aclk);
        run = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  // Monitor: consume scoreboard entries as fetches and param writes appear.
  initial begin
    logic [39:0] e;
    forever begin
      @(negedge aclk);
      #1;
      if (mrd_req) req_seen++;
      if (mrd_req && mrd_ack) begin
        chk_eq("fetch_pending", exp_adr.size() != 0, 1'b1);
        if (exp_adr.size() != 0) chk_eq("fetch_adr", mrd_adr, exp_adr.pop_front());
      end
      if (pwe) begin
        chk_eq("pwe_while_run", run, 1'b0);
        chk_eq("pwe_pending", exp_pw.size() != 0, 1'b1);
        if (exp_pw.size() != 0) begin
          e = exp_pw.pop_front();
          chk_eq("padr", padr, e[39:32]);
          chk_eq("pdata", pdata, e[31:0]);
        end
      end
      if (pwe || kick) chk_eq("pwe_kick_excl", pwe && kick, 1'b0);
      if (kick) begin
        chk_eq("kick_layer", layer_idx, 8'(kick_cnt - kick_base));
        kick_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int req_base;
    bit found;
    arst_n = 1'b0; start = 1'b0; desc_base = 24'd0; n_layers = 8'd0;
    repeat (3) @(negedge aclk);
    chk_reset("reset");
    arst_n = 1'b1;
    @(negedge aclk);

    run_seq(24'h00_0100, 1, 0);
    run_seq(24'h00_1234, 1, 1);
    run_seq(24'h04_0000, 3, 1);

    // Empty sequence: immediate done, no traffic.
    req_base = req_seen;
    pulse_start(24'h00_2000, 0);
    chk_eq("n0_done", done, 1'b1);
    chk_eq("n0_busy", busy, 1'b0);
    repeat (5) @(negedge aclk);
    chk_eq("n0_no_req", req_seen - req_base, 0);
    chk_eq("n0_no_kick", kick_cnt - kick_base, 0);
    chk_eq("n0_done_low", done, 1'b0);

    // Reset while layer 1 is placing lanes, then restart from scratch.
    ack_mode = 0;
    push_layer(24'h01_0000, 0);
    push_layer(24'h01_0000, 1);
    pulse_start(24'h01_0000, 2);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      if (pwe && padr == 8'd24 && layer_idx == 8'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk_eq("reached_split_l1", found, 1'b1);
    arst_n = 1'b0;
    @(negedge aclk);
    chk_reset("midrst");
    arst_n = 1'b1;
    exp_pw.delete();
    exp_adr.delete();
    @(negedge aclk);
    run_seq(24'h02_0080, 1, 0);

`ifdef SEQ_WDOG_EN
    run_en = 1'b0;
    push_layer(24'h03_0000, 0);
    pulse_start(24'h03_0000, 1);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge aclk);
      if (kick) begin
        found = 1'b1;
        break;
      end
    end
    chk_eq("wdog_kick_seen", found, 1'b1);
    wait_done(1200, lat);
    chk_eq("wdog_latency", lat, 1025);
    chk_eq("wdog_err", err, 1'b1);
    chk_eq("wdog_busy", busy, 1'b0);
    pulse_start(24'h03_0000, 0);
    chk_eq("wdog_err_cleared", err, 1'b0);
    run_en = 1'b1;
`else
    chk_eq("err_tied_low", err, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
